// File: rtl/ervp_us_tick_gen.sv
// ervp_us_tick_gen: fractional divider producing tick_1us, cascaded to tick_1ms and tick_1s.
// Define ERVP_TICK_GEN_FRAC_EN to enable the fractional accumulator.
module ervp_us_tick_gen #(
  parameter int BW_INT       = 16,
  parameter int BW_FRAC      = 8,
  parameter int DEFAULT_INT  = 50,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [BW_INT-1:0]  cfg_int,
  input  logic [BW_FRAC-1:0] cfg_frac,
  output logic               tick_1us,
  output logic               tick_1ms,
  output logic               tick_1s
);
  localparam logic [BW_INT-1:0] DEF_INT = (DEFAULT_INT < 2) ? BW_INT'(2) : BW_INT'(DEFAULT_INT);
  localparam logic [BW_INT:0] ONE = 1;
  typedef enum logic {RUN, PEND} state_t;
  state_t state_q, state_d;
  logic [BW_INT-1:0] cyc_cnt_q, cyc_cnt_d, div_int_q, div_int_d, pend_int_q, pend_int_d;
  logic [9:0] us_cnt_q, us_cnt_d, ms_cnt_q, ms_cnt_d;
  logic tick_1us_q, tick_1us_d, tick_1ms_q, tick_1ms_d, tick_1s_q, tick_1s_d;
  logic cfg_ready_q, cfg_ready_d;
  logic [BW_INT:0] lim;
  logic bnd, load, acc, us_wrap, ms_wrap;
`ifdef ERVP_TICK_GEN_FRAC_EN
  logic [BW_FRAC-1:0] frac_q, frac_d, pend_frac_q, pend_frac_d, frac_acc_q, frac_acc_d;
  logic [BW_FRAC:0] sum;
  assign sum = {1'b0, frac_acc_q} + {1'b0, frac_q};
  assign lim = {1'b0, div_int_q} + (BW_INT+1)'(sum[BW_FRAC]);
`else
  localparam int unused_def_frac = DEFAULT_FRAC;
  logic unused_frac;
  assign unused_frac = ^cfg_frac;
  assign lim = {1'b0, div_int_q};
`endif
  // >= rather than == so a divisor loaded mid-period while disabled can never strand the counter
  assign bnd = enable && ({1'b0, cyc_cnt_q} >= lim - ONE);
  assign load = (state_q == PEND) && (bnd || !enable);
  assign acc = cfg_valid && cfg_ready_q;
  assign us_wrap = us_cnt_q == 10'd999;
  assign ms_wrap = ms_cnt_q == 10'd999;
  always_comb begin
    cyc_cnt_d = bnd ? '0 : (enable ? cyc_cnt_q + BW_INT'(1) : cyc_cnt_q);
    us_cnt_d = bnd ? (us_wrap ? '0 : us_cnt_q + 10'd1) : us_cnt_q;
    ms_cnt_d = (bnd && us_wrap) ? (ms_wrap ? '0 : ms_cnt_q + 10'd1) : ms_cnt_q;
    tick_1us_d = bnd;
    tick_1ms_d = bnd && us_wrap;
    tick_1s_d = bnd && us_wrap && ms_wrap;
    div_int_d = load ? pend_int_q : div_int_q;
    pend_int_d = acc ? ((cfg_int < BW_INT'(2)) ? BW_INT'(2) : cfg_int) : pend_int_q;
    state_d = acc ? PEND : (load ? RUN : state_q);
    cfg_ready_d = state_d == RUN;
`ifdef ERVP_TICK_GEN_FRAC_EN
    frac_acc_d = load ? '0 : (bnd ? sum[BW_FRAC-1:0] : frac_acc_q);
    frac_d = load ? pend_frac_q : frac_q;
    pend_frac_d = acc ? cfg_frac : pend_frac_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cyc_cnt_q <= '0;
      div_int_q <= DEF_INT;
      pend_int_q <= DEF_INT;
      us_cnt_q <= '0;
      ms_cnt_q <= '0;
      tick_1us_q <= 1'b0;
      tick_1ms_q <= 1'b0;
      tick_1s_q <= 1'b0;
      cfg_ready_q <= 1'b1;
`ifdef ERVP_TICK_GEN_FRAC_EN
      frac_acc_q <= '0;
      frac_q <= BW_FRAC'(DEFAULT_FRAC);
      pend_frac_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      div_int_q <= div_int_d;
      pend_int_q <= pend_int_d;
      us_cnt_q <= us_cnt_d;
      ms_cnt_q <= ms_cnt_d;
      tick_1us_q <= tick_1us_d;
      tick_1ms_q <= tick_1ms_d;
      tick_1s_q <= tick_1s_d;
      cfg_ready_q <= cfg_ready_d;
`ifdef ERVP_TICK_GEN_FRAC_EN
      frac_acc_q <= frac_acc_d;
      frac_q <= frac_d;
      pend_frac_q <= pend_frac_d;
`endif
    end
  end
  assign cfg_ready = cfg_ready_q;
  assign tick_1us = tick_1us_q;
  assign tick_1ms = tick_1ms_q;
  assign tick_1s = tick_1s_q;
endmodule

// File: tb/tb_ervp_us_tick_gen.sv
// tb_ervp_us_tick_gen: randomized directed bench with a period-arithmetic reference model.
module tb_ervp_us_tick_gen;
  logic clk = 1'b0;
  logic rst, enable, cfg_valid, cfg_ready, tick_1us, tick_1ms, tick_1s;
  logic [15:0] cfg_int;
  logic [7:0] cfg_frac;
  int checks = 0, failures = 0, tcount = 0, cur_int = 50, cur_frac = 0, k = 1;
  bit forced = 1'b0;

  ervp_us_tick_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .tick_1us(tick_1us), .tick_1ms(tick_1ms), .tick_1s(tick_1s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Period k after a load: int_eff plus the number of 2^8 wraps of k*frac crossed in that period
  function automatic int exp_period(input int kk);
`ifdef ERVP_TICK_GEN_FRAC_EN
    return cur_int + ((kk * cur_frac) >> 8) - (((kk - 1) * cur_frac) >> 8);
`else
    return cur_int;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (tick_1us === 1'b1) tcount++;
    chk("tick_1ms", tick_1ms, 32'(tick_1us === 1'b1 && tcount % 1000 == 0));
    chk("tick_1s", tick_1s, 32'(tick_1us === 1'b1 && tcount % 1000 == 0 && forced));
  endtask

  task automatic run_to_tick(input int d, input int eoff, input int elen, output int n, output logic rdy);
    bit done = 1'b0;
    n = 0;
    rdy = 1'bx;
    while (!done && n < 3000) begin
      enable = !(n >= eoff && n < eoff + elen);
      cfg_valid = (n == d);
      step();
      n++;
      if (n == d + 1) rdy = cfg_ready;
      if (tick_1us === 1'b1) done = 1'b1;
    end
    cfg_valid = 1'b0;
    enable = 1'b1;
    if (!done) chk("tick_timeout", 32'(done), 1);
  endtask

  task automatic period_chk(input string tag);
    int n;
    logic r;
    run_to_tick(-1, -1, 0, n, r);
    chk(tag, n, exp_period(k));
    k++;
  endtask

  task automatic apply_cfg(input int ci, input int cf, input int dsel);
    int p, n, d;
    logic r;
    cfg_int = 16'(ci);
    cfg_frac = 8'(cf);
    p = exp_period(k);
    d = (dsel < 0) ? int'($urandom_range(p - 1, 0)) : dsel;
    run_to_tick(d, -1, 0, n, r);
    chk("old_period", n, p);
    chk("ready_after_accept", r, 0);
    k++;
    if (d + 1 == p) begin
      chk("ready_pend", cfg_ready, 0);
      run_to_tick(-1, -1, 0, n, r);
      chk("extra_old_period", n, exp_period(k));
    end
    chk("ready_after_load", cfg_ready, 1);
    cur_int = (ci < 2) ? 2 : ci;
    cur_frac = cf;
    k = 1;
    repeat (3) period_chk("new_period");
  endtask

  initial begin
    int n, p, e;
    logic r;
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_int = '0; cfg_frac = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick_1us", tick_1us, 0);
    chk("rst_tick_1ms", tick_1ms, 0);
    chk("rst_tick_1s", tick_1s, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;
    enable = 1'b1;
    period_chk("first_tick");
    period_chk("default_period");
    period_chk("default_period");
    apply_cfg(10, 0, 20);
    apply_cfg(0, 0, -1);
    apply_cfg(1, 0, -1);
    apply_cfg(2, 0, -1);
    apply_cfg(50, 128, -1);
    period_chk("frac_period");
    repeat (6) apply_cfg(int'($urandom_range(40, 0)), int'($urandom_range(255, 0)), -1);
    apply_cfg(50, 0, -1);
    run_to_tick(-1, 30, 7, n, r);
    chk("enable_gap_57", n, 57);
    k++;
    p = exp_period(k);
    e = int'($urandom_range(9, 1));
    run_to_tick(-1, int'($urandom_range(p - 1, 0)), e, n, r);
    chk("enable_gap_rand", n, p + e);
    k++;
    apply_cfg(2, 0, -1);
    while (tcount < 1000) period_chk("cascade_period");
    force dut.ms_cnt_q = 10'd999;
    forced = 1'b1;
    while (tcount < 2000) period_chk("cascade_period");
    release dut.ms_cnt_q;
    forced = 1'b0;
    cfg_int = 16'd10;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("pend_ready", cfg_ready, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_tick_1us", tick_1us, 0);
    chk("mid_rst_tick_1ms", tick_1ms, 0);
    chk("mid_rst_tick_1s", tick_1s, 0);
    chk("mid_rst_ready", cfg_ready, 1);
    rst = 1'b0;
    tcount = 0;
    cur_int = 50;
    cur_frac = 0;
    k = 1;
    period_chk("post_rst_first");
    period_chk("post_rst_period");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
